// File: rtl/rv32_fetch_queue.sv
// Decoupled RV32 fetch stage: PC generator, static branch predictor, prefetch queue and
// fetch/decode output register. Redirects that arrive during a pending read are parked until it completes.
module rv32_fetch_queue #(
    parameter logic [31:0] RESET_VECTOR      = 32'h0000_0000,
    parameter int          BRANCH_PREDICTION = 0,
    parameter int          QUEUE_DEPTH       = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall_in,
    input  logic                               flush_in,
    input  logic                               trap_in,
    input  logic                               branch_mispredicted_in,
    input  logic [31:0]                        trap_pc_in,
    input  logic [31:0]                        branch_pc_in,
    output logic                               instr_read_out,
    output logic [31:0]                        instr_address_out,
    input  logic                               instr_ready_in,
    input  logic [31:0]                        instr_read_value_in,
    input  logic                               instr_fault_in,
    output logic                               overwrite_pc_out,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_level_out,
    output logic                               valid_out,
    output logic                               exception_out,
    output logic [3:0]                         exception_cause_out,
    output logic                               branch_predicted_taken_out,
    output logic [31:0]                        pc_out,
    output logic [31:0]                        instr_out
);
    localparam int          LW          = $clog2(QUEUE_DEPTH + 1);
    localparam int          PW          = $clog2(QUEUE_DEPTH);
    localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;
    localparam logic [3:0]  CAUSE_FAULT = 4'd1;
    localparam logic [6:0]  OP_JAL      = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
    localparam logic        PRED_JAL    = (BRANCH_PREDICTION == 32'sd1) || (BRANCH_PREDICTION == 32'sd2);
    localparam logic        PRED_BRANCH = (BRANCH_PREDICTION == 32'sd1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1'b1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
        logic        pred;
    } entry_t;

    entry_t          q_mem_r [QUEUE_DEPTH];
    logic [PW-1:0]   rd_ptr_r, wr_ptr_r;
    logic [LW-1:0]   level_r;
    logic [31:0]     pc_r, target_r;
    logic            overwrite_r;

    logic            valid_r, exception_r, pred_out_r;
    logic [3:0]      cause_r;
    logic [31:0]     pc_out_r, instr_out_r;

    logic            redirect_s, pop_s, read_s, accept_s, push_s;
    logic [31:0]     redirect_target_s, offset_s, imm_j_s, imm_b_s;
    logic            pred_taken_s;
    entry_t          head_s, new_entry_s;

    assign redirect_s        = trap_in | branch_mispredicted_in;
    assign redirect_target_s = trap_in ? trap_pc_in : branch_pc_in;
    assign pop_s             = !stall_in && (level_r != '0) && !redirect_s;
    assign read_s            = !reset && ((level_r < LW'(QUEUE_DEPTH)) || pop_s || overwrite_r);
    assign accept_s          = read_s && instr_ready_in;
    assign push_s            = accept_s && !redirect_s && !overwrite_r;
    assign head_s            = q_mem_r[rd_ptr_r];

    assign imm_j_s = {{12{instr_read_value_in[31]}}, instr_read_value_in[19:12],
                      instr_read_value_in[20], instr_read_value_in[30:21], 1'b0};
    assign imm_b_s = {{20{instr_read_value_in[31]}}, instr_read_value_in[7],
                      instr_read_value_in[30:25], instr_read_value_in[11:8], 1'b0};

    // Static prediction on the returning word; a faulted read always falls through.
    always_comb begin
        pred_taken_s = 1'b0;
        offset_s     = 32'd4;
        if (instr_fault_in) begin
            pred_taken_s = 1'b0;
            offset_s     = 32'd4;
        end else if (PRED_JAL && (instr_read_value_in[6:0] == OP_JAL)) begin
            pred_taken_s = 1'b1;
            offset_s     = imm_j_s;
        end else if (PRED_BRANCH && (instr_read_value_in[6:0] == OP_BRANCH) && instr_read_value_in[31]) begin
            pred_taken_s = 1'b1;
            offset_s     = imm_b_s;
        end else begin
            pred_taken_s = 1'b0;
            offset_s     = 32'd4;
        end
    end

    assign new_entry_s = '{pc:    pc_r,
                           instr: instr_fault_in ? INSTR_NOP : instr_read_value_in,
                           fault: instr_fault_in,
                           pred:  pred_taken_s};

    // Queue storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_mem_r[wr_ptr_r] <= new_entry_s;
        end
    end

    // Fetch PC, parked redirect target and queue bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r        <= RESET_VECTOR;
            target_r    <= 32'h0000_0000;
            overwrite_r <= 1'b0;
            rd_ptr_r    <= '0;
            wr_ptr_r    <= '0;
            level_r     <= '0;
        end else if (redirect_s) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            level_r  <= '0;
            if (read_s && !instr_ready_in) begin
                overwrite_r <= 1'b1;
                target_r    <= redirect_target_s;
            end else begin
                overwrite_r <= 1'b0;
                pc_r        <= redirect_target_s;
            end
        end else begin
            if (accept_s && overwrite_r) begin
                overwrite_r <= 1'b0;
                pc_r        <= target_r;
            end else if (push_s) begin
                pc_r <= pc_r + offset_s;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                level_r <= level_r + LVL_ONE;
            end else if (pop_s && !push_s) begin
                level_r <= level_r - LVL_ONE;
            end
        end
    end

    // Fetch/decode output register: holds on stall, otherwise head of queue or a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r     <= 1'b0;
            exception_r <= 1'b0;
            cause_r     <= 4'd0;
            pred_out_r  <= 1'b0;
            pc_out_r    <= 32'h0000_0000;
            instr_out_r <= INSTR_NOP;
        end else if (!stall_in) begin
            if (pop_s && !flush_in) begin
                valid_r     <= !head_s.fault;
                exception_r <= head_s.fault;
                cause_r     <= head_s.fault ? CAUSE_FAULT : 4'd0;
                pred_out_r  <= head_s.pred;
                pc_out_r    <= head_s.pc;
                instr_out_r <= head_s.instr;
            end else begin
                valid_r     <= 1'b0;
                exception_r <= 1'b0;
                cause_r     <= 4'd0;
                pred_out_r  <= 1'b0;
                pc_out_r    <= 32'h0000_0000;
                instr_out_r <= INSTR_NOP;
            end
        end
    end

    assign instr_read_out             = read_s;
    assign instr_address_out          = pc_r;
    assign overwrite_pc_out           = overwrite_r;
    assign queue_level_out            = level_r;
    assign valid_out                  = valid_r;
    assign exception_out              = exception_r;
    assign exception_cause_out        = cause_r;
    assign branch_predicted_taken_out = pred_out_r;
    assign pc_out                     = pc_out_r;
    assign instr_out                  = instr_out_r;

endmodule

// File: tb/tb_rv32_fetch_queue.sv
// Randomized scoreboard bench for rv32_fetch_queue: a transaction-level model predicts every
// cycle's output register, queue level and fetch requests; a separate monitor compares.
module tb_rv32_fetch_queue;
    localparam int          DEPTH = 4;
    localparam int          BP    = 1;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          NCYC  = 4000;

    logic        clk = 1'b0;
    logic        reset = 1'b1, stall_in = 1'b0, flush_in = 1'b0, trap_in = 1'b0, branch_mispredicted_in = 1'b0;
    logic [31:0] trap_pc_in = 32'h0, branch_pc_in = 32'h0, instr_read_value_in = 32'h0;
    logic        instr_ready_in = 1'b0, instr_fault_in = 1'b0;
    logic        instr_read_out, overwrite_pc_out, valid_out, exception_out, branch_predicted_taken_out;
    logic [31:0] instr_address_out, pc_out, instr_out;
    logic [2:0]  queue_level_out;
    logic [3:0]  exception_cause_out;

    rv32_fetch_queue #(.RESET_VECTOR(RV), .BRANCH_PREDICTION(BP), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in), .trap_in(trap_in),
        .branch_mispredicted_in(branch_mispredicted_in), .trap_pc_in(trap_pc_in),
        .branch_pc_in(branch_pc_in), .instr_read_out(instr_read_out),
        .instr_address_out(instr_address_out), .instr_ready_in(instr_ready_in),
        .instr_read_value_in(instr_read_value_in), .instr_fault_in(instr_fault_in),
        .overwrite_pc_out(overwrite_pc_out), .queue_level_out(queue_level_out),
        .valid_out(valid_out), .exception_out(exception_out),
        .exception_cause_out(exception_cause_out),
        .branch_predicted_taken_out(branch_predicted_taken_out), .pc_out(pc_out), .instr_out(instr_out));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
        logic        pred;
    } ent_t;

    typedef struct {
        logic        valid;
        logic        exc;
        logic [3:0]  cause;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] instr;
        int          level;
        logic        ovw;
    } out_t;

    out_t        exp_q[$];
    ent_t        mq[$];
    logic [31:0] mem_w [64];
    logic        mem_f [64];
    int          tests = 0, fails = 0;
    logic        started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Target of a fetched word under the chosen prediction mode.
    function automatic logic [31:0] next_pc(input logic [31:0] pc, input logic [31:0] w, output logic taken);
        int j, b;
        j = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
        b = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
        taken = 1'b0;
        if (w[6:0] == 7'b1101111 && BP != 0) begin
            taken = 1'b1;
            return pc + 32'(j);
        end
        if (w[6:0] == 7'b1100011 && b < 0 && BP == 1) begin
            taken = 1'b1;
            return pc + 32'(b);
        end
        return pc + 32'd4;
    endfunction

    // Monitor: one expected snapshot per clock edge.
    initial begin
        out_t e;
        wait (started);
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_starved: got no expectation, required one per cycle");
            end else begin
                e = exp_q.pop_front();
                check("valid_out", 32'(valid_out), 32'(e.valid));
                check("exception_out", 32'(exception_out), 32'(e.exc));
                check("exception_cause", 32'(exception_cause_out), 32'(e.cause));
                check("pred_taken", 32'(branch_predicted_taken_out), 32'(e.pred));
                check("pc_out", pc_out, e.pc);
                check("instr_out", instr_out, e.instr);
                check("queue_level", 32'(queue_level_out), 32'(e.level));
                check("overwrite_pc", 32'(overwrite_pc_out), 32'(e.ovw));
            end
        end
    end

    // Stimulus and reference model.
    initial begin
        logic [31:0] mpc, ptgt, tgt, w;
        logic        pend, exp_read, pop, redirect, acc, tk;
        int          r;
        ent_t        head, ne;
        out_t        mout, o;

        for (int k = 0; k < 64; k++) begin
            r = $urandom_range(0, 3);
            w = $urandom;
            case (r)
                0:       w = NOP;
                1:       w[6:0] = 7'b1101111;
                2:       w[6:0] = 7'b1100011;
                default: w = w;
            endcase
            mem_w[k] = w;
            mem_f[k] = ($urandom_range(0, 15) == 0);
        end
        mpc  = RV;
        pend = 1'b0;
        ptgt = 32'h0;
        mout = '{valid: 1'b0, exc: 1'b0, cause: 4'd0, pred: 1'b0, pc: 32'h0, instr: NOP, level: 0, ovw: 1'b0};

        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            #1;
            reset    = (i < 3) || (i >= 2000 && i < 2003);
            stall_in = (i >= 300 && i < 310) ? 1'b1 : ($urandom_range(0, 3) == 0);
            flush_in = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 39);
            trap_in                = (r < 2);
            branch_mispredicted_in = (r == 1) || (r == 2);
            trap_pc_in     = 32'($urandom_range(0, 63)) << 2;
            branch_pc_in   = 32'($urandom_range(0, 63)) << 2;
            instr_ready_in = (i >= 300 && i < 310) ? 1'b1 : ($urandom_range(0, 9) < 6);
            #1;
            instr_read_value_in = mem_w[instr_address_out[7:2]];
            instr_fault_in      = mem_f[instr_address_out[7:2]];

            redirect = trap_in || branch_mispredicted_in;
            tgt      = trap_in ? trap_pc_in : branch_pc_in;
            pop      = !stall_in && mq.size() != 0 && !redirect;
            exp_read = !reset && (mq.size() < DEPTH || pop || pend);
            check("instr_read", 32'(instr_read_out), 32'(exp_read));
            if (exp_read) check("instr_address", instr_address_out, mpc);

            if (reset) begin
                mq.delete();
                mpc  = RV;
                pend = 1'b0;
                mout = '{valid: 1'b0, exc: 1'b0, cause: 4'd0, pred: 1'b0, pc: 32'h0, instr: NOP, level: 0, ovw: 1'b0};
            end else begin
                acc = exp_read && instr_ready_in;
                if (pop) head = mq.pop_front();
                if (!stall_in) begin
                    if (pop && !flush_in)
                        mout = '{valid: !head.fault, exc: head.fault, cause: head.fault ? 4'd1 : 4'd0,
                                 pred: head.pred, pc: head.pc, instr: head.instr, level: 0, ovw: 1'b0};
                    else
                        mout = '{valid: 1'b0, exc: 1'b0, cause: 4'd0, pred: 1'b0, pc: 32'h0, instr: NOP, level: 0, ovw: 1'b0};
                end
                if (redirect) begin
                    mq.delete();
                    if (exp_read && !instr_ready_in) begin
                        pend = 1'b1;
                        ptgt = tgt;
                    end else begin
                        pend = 1'b0;
                        mpc  = tgt;
                    end
                end else if (acc) begin
                    if (pend) begin
                        pend = 1'b0;
                        mpc  = ptgt;
                    end else if (mem_f[mpc[7:2]]) begin
                        ne = '{pc: mpc, instr: NOP, fault: 1'b1, pred: 1'b0};
                        mq.push_back(ne);
                        mpc = mpc + 32'd4;
                    end else begin
                        w  = mem_w[mpc[7:2]];
                        ne = '{pc: mpc, instr: w, fault: 1'b0, pred: 1'b0};
                        mpc = next_pc(mpc, w, tk);
                        ne.pred = tk;
                        mq.push_back(ne);
                    end
                end
            end
            o       = mout;
            o.level = mq.size();
            o.ovw   = pend;
            exp_q.push_back(o);
            started = 1'b1;
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
